// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants, requester indices and lock-state encoding
// for the sram_4096x8 image-buffer arbiter.
//   ADDR_W / DATA_W : SRAM address and data widths
//   REQ_IMG/DEC/ENG : requester slot indices (image writer, decoder, conv engine)
//   lock_state_t    : ST_IDLE (round-robin) / ST_OWNED (locked burst)
package sram_arb_pkg;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int REQ_IMG = 0;
    localparam int REQ_DEC = 1;
    localparam int REQ_ENG = 2;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } lock_state_t;
endpackage

// File: rtl/sram_share_arbiter_if.sv
// sram_share_arbiter_if: requester-side bus of the SRAM arbiter.
//   req/we/lock : per-requester request, write flag and lock request
//   addr/wdata  : packed per-requester address and write data (slot k at k*W)
//   gnt         : one-hot access accepted this cycle
//   rvalid      : one-hot read data valid for requester k
//   rdata       : shared read data
// master = requesters, slave = arbiter.
interface sram_share_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_rr_picker.sv
// sram_rr_picker: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot winner (zero when no request)
//   idx : winner index (don't-care when no request)
module sram_rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);
    logic [2*N_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;
    // Rotate so ptr lands at bit 0; the lowest set bit is the distance to the winner.
    always_comb begin
        rot = {req, req} >> ptr;
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = sum >= (IDX_W+1)'(N_REQ) ? IDX_W'(sum - (IDX_W+1)'(N_REQ)) : IDX_W'(sum);
        gnt = (|req) ? N_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/sram_share_arbiter.sv
// sram_share_arbiter: round-robin SRAM arbiter with bounded locked bursts.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   bus (slave)     : requester bus (req/we/lock/addr/wdata in, gnt/rvalid/rdata out)
//   o_sram_*        : single-port SRAM pins (active-low cen/wen)
//   i_sram_q        : SRAM read data, returned unregistered on bus.rdata
//   o_busy          : a requester currently owns the lock
module sram_share_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = sram_arb_pkg::ADDR_W,
    parameter int DATA_W   = sram_arb_pkg::DATA_W,
    parameter int MAX_LOCK = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sram_share_arbiter_if.slave  bus,
    output logic                 o_sram_cen,
    output logic                 o_sram_wen,
    output logic [ADDR_W-1:0]    o_sram_addr,
    output logic [DATA_W-1:0]    o_sram_d,
    input  logic [DATA_W-1:0]    i_sram_q,
    output logic                 o_busy
);
    localparam int IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1;

    lock_state_t      state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, owner, owner_nxt, pick_idx, gidx;
    logic [7:0]       lock_cnt, lock_cnt_nxt;
    logic [N_REQ-1:0] pick_gnt, gnt, rvalid_q;
    logic             granted, g_we, g_lock;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(N_REQ - 1)) ? '0 : k + IDX_W'(1);
    endfunction

    sram_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            lock_cnt <= '0;
            rr_ptr   <= IDX_W'(REQ_IMG);
            rvalid_q <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            rvalid_q <= gnt & ~bus.we;
        end
    end

    // lock_cnt counts held cycles including the current one once incremented;
    // reaching MAX_LOCK releases after this cycle's grant.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        rr_ptr_nxt   = rr_ptr;
        if (state == ST_IDLE) begin
            if (granted && g_lock) begin
                state_nxt    = ST_OWNED;
                owner_nxt    = pick_idx;
                lock_cnt_nxt = 8'd1;
            end else if (granted) begin
                rr_ptr_nxt = next_idx(pick_idx);
            end
        end else begin
            lock_cnt_nxt = lock_cnt == 8'hff ? lock_cnt : lock_cnt + 8'd1;
            if (!bus.lock[owner] || lock_cnt_nxt >= 8'(MAX_LOCK)) begin
                state_nxt    = ST_IDLE;
                owner_nxt    = '0;
                lock_cnt_nxt = '0;
                rr_ptr_nxt   = next_idx(owner);
            end
        end
    end

    // While owned, only the owner may be granted; everyone else stalls.
    always_comb begin
        gidx        = state == ST_OWNED ? owner : pick_idx;
        gnt         = state == ST_OWNED ? (bus.req[owner] ? N_REQ'(1) << owner : '0) : pick_gnt;
        granted     = |gnt;
        g_we        = bus.we[gidx];
        g_lock      = bus.lock[gidx];
        o_sram_cen  = ~granted;
        o_sram_wen  = ~(granted & g_we);
        o_sram_addr = granted ? bus.addr[gidx*ADDR_W +: ADDR_W] : '0;
        o_sram_d    = granted ? bus.wdata[gidx*DATA_W +: DATA_W] : '0;
        o_busy      = state == ST_OWNED;
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = i_sram_q;
endmodule

// File: tb/tb_sram_share_arbiter.sv
// tb_sram_share_arbiter: directed self-checking bench for sram_share_arbiter.
// dut_a uses MAX_LOCK = 64, dut_b MAX_LOCK = 4; both see the same requests.
module tb_sram_share_arbiter;
    import sram_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req, we, lock;
    logic [35:0] addr;
    logic [23:0] wdata;
    logic       cen_a, wen_a, busy_a, cen_b, wen_b, busy_b;
    logic [11:0] saddr_a, saddr_b;
    logic [7:0]  d_a, d_b;
    logic [7:0]  q = 8'h00;
    logic [7:0]  mem [4096];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sram_share_arbiter_if bus_a ();
    sram_share_arbiter_if bus_b ();

    assign bus_a.req = req;   assign bus_b.req = req;
    assign bus_a.we = we;     assign bus_b.we = we;
    assign bus_a.lock = lock; assign bus_b.lock = lock;
    assign bus_a.addr = addr; assign bus_b.addr = addr;
    assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;

    sram_share_arbiter dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a),
        .o_sram_cen(cen_a), .o_sram_wen(wen_a), .o_sram_addr(saddr_a),
        .o_sram_d(d_a), .i_sram_q(q), .o_busy(busy_a)
    );

    sram_share_arbiter #(.MAX_LOCK(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b),
        .o_sram_cen(cen_b), .o_sram_wen(wen_b), .o_sram_addr(saddr_b),
        .o_sram_d(d_b), .i_sram_q(q), .o_busy(busy_b)
    );

    // Behavioural sram_4096x8 behind dut_a: 1-cycle read latency.
    always @(posedge clk)
        if (!cen_a) begin
            if (!wen_a) mem[saddr_a] <= d_a;
            else q <= mem[saddr_a];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
        req = r;
        we = w;
        lock = l;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 3'b000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_g [4];
        logic [2:0] exp_v [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_v = '{3'b000, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        drive(3'b000, 3'b000, 3'b000);
        addr = '0;
        wdata = '0;
        // Reset state
        @(negedge clk);
        check("rst_gnt", bus_a.gnt, 3'b000);
        check("rst_cen", cen_a, 1'b1);
        check("rst_wen", wen_a, 1'b1);
        check("rst_addr", saddr_a, 12'h000);
        check("rst_d", d_a, 8'h00);
        check("rst_rvalid", bus_a.rvalid, 3'b000);
        check("rst_busy", busy_a, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // All three reading continuously: strict rotation
        drive(3'b111, 3'b000, 3'b000);
        addr = {12'h300, 12'h200, 12'h100};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rot_gnt%0d", i), bus_a.gnt, exp_g[i]);
            check($sformatf("rot_rvalid%0d", i), bus_a.rvalid, exp_v[i]);
            tick();
        end
        // Write by image writer, read back by decoder
        do_reset();
        drive(3'b001, 3'b001, 3'b000);
        addr = {12'h000, 12'h000, 12'h010};
        wdata = {8'h00, 8'h00, 8'h5A};
        @(negedge clk);
        check("wr_gnt", bus_a.gnt, 3'b001);
        check("wr_cen", cen_a, 1'b0);
        check("wr_wen", wen_a, 1'b0);
        check("wr_addr", saddr_a, 12'h010);
        check("wr_d", d_a, 8'h5A);
        tick();
        drive(3'b010, 3'b000, 3'b000);
        addr = {12'h000, 12'h010, 12'h000};
        @(negedge clk);
        check("rd_gnt", bus_a.gnt, 3'b010);
        check("rd_wen", wen_a, 1'b1);
        check("rd_addr", saddr_a, 12'h010);
        check("wr_no_rvalid", bus_a.rvalid, 3'b000);
        tick();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        check("rd_rvalid", bus_a.rvalid, 3'b010);
        check("rd_rdata", bus_a.rdata, 8'h5A);
        // Locked burst by conv engine while image writer waits
        do_reset();
        drive(3'b100, 3'b000, 3'b100);
        @(negedge clk);
        check("lk_gnt0", bus_a.gnt, 3'b100);
        check("lk_busy0", busy_a, 1'b0);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(3'b101, 3'b000, i == 4 ? 3'b000 : 3'b100);
            @(negedge clk);
            check($sformatf("lk_gnt%0d", i), bus_a.gnt, 3'b100);
            check($sformatf("lk_busy%0d", i), busy_a, 1'b1);
            check($sformatf("lk_rvalid%0d", i), bus_a.rvalid, 3'b100);
            tick();
        end
        drive(3'b001, 3'b000, 3'b000);
        @(negedge clk);
        check("lk_rel_gnt", bus_a.gnt, 3'b001);
        check("lk_rel_busy", busy_a, 1'b0);
        // Forced release at MAX_LOCK = 4 (dut_b)
        do_reset();
        drive(3'b010, 3'b000, 3'b010);
        @(negedge clk);
        check("to_gnt0", bus_b.gnt, 3'b010);
        tick();
        drive(3'b110, 3'b000, 3'b010);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("to_gnt%0d", i), bus_b.gnt, 3'b010);
            check($sformatf("to_busy%0d", i), busy_b, 1'b1);
            tick();
        end
        @(negedge clk);
        check("to_rel_gnt", bus_b.gnt, 3'b100);
        check("to_rel_busy", busy_b, 1'b0);
        check("to_a_still", bus_a.gnt, 3'b010);
        // Writes only: never any rvalid
        do_reset();
        drive(3'b001, 3'b001, 3'b000);
        for (int i = 0; i < 8; i++) begin
            addr = {24'h0, 12'(12'h020 + i)};
            wdata = {16'h0, 8'(8'hA0 + i)};
            @(negedge clk);
            check($sformatf("wo_gnt%0d", i), bus_a.gnt, 3'b001);
            check($sformatf("wo_rvalid%0d", i), bus_a.rvalid, 3'b000);
            tick();
        end
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        check("wo_rvalid_end", bus_a.rvalid, 3'b000);
        // Reset in the middle of a locked read burst
        do_reset();
        drive(3'b010, 3'b000, 3'b010);
        @(negedge clk);
        check("mr_gnt", bus_a.gnt, 3'b010);
        tick();
        check("mr_rvalid_pre", bus_a.rvalid, 3'b010);
        check("mr_busy_pre", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid_rst", bus_a.rvalid, 3'b000);
        check("mr_busy_rst", busy_a, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(3'b011, 3'b000, 3'b000);
        @(negedge clk);
        check("mr_fresh_gnt", bus_a.gnt, 3'b001);
        check("mr_fresh_rvalid", bus_a.rvalid, 3'b000);
        tick();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        check("mr_next_rvalid", bus_a.rvalid, 3'b001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
